// File: rtl/dcache_sa_if.sv
// rtl/dcache_sa_if.sv - pipeline-side and line-memory-side signal bundle for dcache_sa
interface dcache_sa_if #(
  parameter int LINE_BITS = 128
);
  // pipeline side
  logic                 req_valid;
  logic                 req_write;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic [2:0]           req_funct3;
  logic                 flush_req;
  logic [31:0]          rdata;
  logic                 hit;
  logic                 busy;
  logic                 misaligned;
  logic                 flush_done;
  // line memory side
  logic                 mem_req_valid;
  logic                 mem_req_write;
  logic [31:0]          mem_req_addr;
  logic [LINE_BITS-1:0] mem_wdata;
  logic                 mem_ready;
  logic [LINE_BITS-1:0] mem_rdata;

  // cache view
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, flush_req,
    input  mem_ready, mem_rdata,
    output rdata, hit, busy, misaligned, flush_done,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_wdata
  );

  // pipeline + memory view
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, flush_req,
    output mem_ready, mem_rdata,
    input  rdata, hit, busy, misaligned, flush_done,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_sa.sv
// rtl/dcache_sa.sv - N-way set-associative write-back, write-allocate data cache with flush
module dcache_sa #(
  parameter int LINE_BITS = 128,
  parameter int NUM_SETS  = 4,
  parameter int NUM_WAYS  = 2
) (
  input  logic       clk,
  input  logic       reset,
  dcache_sa_if.slave bus
);

  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WSEL_W = OFF_W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_FLUSH_SCAN,
    S_FLUSH_WB
  } state_t;

  state_t               state_q, state_d;
  logic [TAG_W-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]     tag_d   [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] data_d  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]  valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0]  dirty_d [NUM_SETS];
  logic [WAY_W-1:0]     rr_q    [NUM_SETS];
  logic [WAY_W-1:0]     rr_d    [NUM_SETS];

  // miss bookkeeping survives req_valid dropping mid-transaction
  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]     miss_idx_q, miss_idx_d;
  logic [WAY_W-1:0]     victim_q, victim_d;
  logic [IDX_W-1:0]     fl_set_q, fl_set_d;
  logic [WAY_W-1:0]     fl_way_q, fl_way_d;

  logic                 mem_req_valid_q, mem_req_valid_d;
  logic                 mem_req_write_q, mem_req_write_d;
  logic [31:0]          mem_req_addr_q, mem_req_addr_d;
  logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic                 flush_done_q, flush_done_d;

  // request field decode
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_wsel;
  logic              is_byte, is_half, is_word, req_mis, acc_ok;

  assign req_tag  = bus.req_addr[31 -: TAG_W];
  assign req_idx  = bus.req_addr[OFF_W +: IDX_W];
  assign req_wsel = bus.req_addr[2 +: WSEL_W];
  assign is_byte  = (bus.req_funct3[1:0] == 2'b00);
  assign is_half  = (bus.req_funct3[1:0] == 2'b01);
  assign is_word  = bus.req_funct3[1];
  assign req_mis  = (is_half && bus.req_addr[0]) || (is_word && (bus.req_addr[1:0] != 2'b00));
  assign acc_ok   = bus.req_valid && !req_mis;

  // flush scan counter walks ways fastest, then sets
  logic             fl_wrap, fl_last;
  logic [WAY_W-1:0] fl_way_nxt;
  logic [IDX_W-1:0] fl_set_nxt;

  assign fl_wrap    = (int'(fl_way_q) == NUM_WAYS - 1);
  assign fl_last    = fl_wrap && (int'(fl_set_q) == NUM_SETS - 1);
  assign fl_way_nxt = fl_wrap ? '0 : fl_way_q + 1'b1;
  assign fl_set_nxt = fl_wrap ? fl_set_q + 1'b1 : fl_set_q;

  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic             found_inv;

  // tag compare across the indexed set and victim choice (lowest invalid, else round robin)
  always_comb begin
    hit_any    = 1'b0;
    hit_way    = '0;
    victim_way = rr_q[req_idx];
    found_inv  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!found_inv && !valid_q[req_idx][w]) begin
        found_inv  = 1'b1;
        victim_way = WAY_W'(w);
      end
    end
  end

  logic [LINE_BITS-1:0] hit_line;
  logic [31:0]          hit_word, load_val, store_word;
  logic [7:0]           lane_byte;
  logic [15:0]          lane_half;

  assign hit_line  = data_q[req_idx][hit_way];
  assign hit_word  = hit_line[{req_wsel, 5'b00000} +: 32];
  assign lane_byte = hit_word[{bus.req_addr[1:0], 3'b000} +: 8];
  assign lane_half = hit_word[{bus.req_addr[1], 4'b0000} +: 16];

  // load extension and store merge on the selected word
  always_comb begin
    load_val   = hit_word;
    store_word = hit_word;
    if (is_byte) begin
      load_val = bus.req_funct3[2] ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      store_word[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
    end else if (is_half) begin
      load_val = bus.req_funct3[2] ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
      store_word[{bus.req_addr[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
    end else begin
      store_word = bus.req_wdata;
    end
  end

  // pipeline-facing status: hits resolve in IDLE, everything else stalls
  always_comb begin
    bus.rdata      = '0;
    bus.hit        = 1'b0;
    bus.busy       = 1'b0;
    bus.misaligned = 1'b0;
    if (bus.req_valid) begin
      if (state_q != S_IDLE) begin
        bus.busy = 1'b1;
      end else if (req_mis) begin
        bus.misaligned = 1'b1;
      end else if (hit_any) begin
        bus.hit   = 1'b1;
        bus.rdata = load_val;
      end else begin
        bus.busy = 1'b1;
      end
    end
  end

  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_write = mem_req_write_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.flush_done    = flush_done_q;

  // controller next state, array updates and registered memory request
  always_comb begin
    state_d         = state_q;
    tag_d           = tag_q;
    data_d          = data_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    rr_d            = rr_q;
    miss_tag_d      = miss_tag_q;
    miss_idx_d      = miss_idx_q;
    victim_d        = victim_q;
    fl_set_d        = fl_set_q;
    fl_way_d        = fl_way_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_write_d = mem_req_write_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_wdata_d     = mem_wdata_q;
    flush_done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (acc_ok && hit_any && bus.req_write) begin
          data_d[req_idx][hit_way][{req_wsel, 5'b00000} +: 32] = store_word;
          dirty_d[req_idx][hit_way] = 1'b1;
        end
        if (bus.flush_req) begin
          state_d  = S_FLUSH_SCAN;
          fl_set_d = '0;
          fl_way_d = '0;
        end else if (acc_ok && !hit_any) begin
          miss_tag_d      = req_tag;
          miss_idx_d      = req_idx;
          victim_d        = victim_way;
          mem_req_valid_d = 1'b1;
          if (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) begin
            state_d         = S_WB;
            mem_req_write_d = 1'b1;
            mem_req_addr_d  = {tag_q[req_idx][victim_way], req_idx, {OFF_W{1'b0}}};
            mem_wdata_d     = data_q[req_idx][victim_way];
          end else begin
            state_d         = S_FILL;
            mem_req_write_d = 1'b0;
            mem_req_addr_d  = {req_tag, req_idx, {OFF_W{1'b0}}};
          end
        end
      end

      S_WB: begin
        if (bus.mem_ready) begin
          mem_req_valid_d = 1'b0;
          mem_req_write_d = 1'b0;
          state_d         = S_FILL;
        end
      end

      S_FILL: begin
        if (!mem_req_valid_q) begin
          // dead cycle after a writeback: raise the fill request now
          mem_req_valid_d = 1'b1;
          mem_req_write_d = 1'b0;
          mem_req_addr_d  = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
        end else if (bus.mem_ready) begin
          data_d[miss_idx_q][victim_q]  = bus.mem_rdata;
          tag_d[miss_idx_q][victim_q]   = miss_tag_q;
          valid_d[miss_idx_q][victim_q] = 1'b1;
          dirty_d[miss_idx_q][victim_q] = 1'b0;
          rr_d[miss_idx_q] = (int'(rr_q[miss_idx_q]) == NUM_WAYS - 1) ? '0
                                                                       : rr_q[miss_idx_q] + 1'b1;
          mem_req_valid_d = 1'b0;
          state_d         = S_IDLE;
        end
      end

      S_FLUSH_SCAN: begin
        if (valid_q[fl_set_q][fl_way_q] && dirty_q[fl_set_q][fl_way_q]) begin
          state_d         = S_FLUSH_WB;
          mem_req_valid_d = 1'b1;
          mem_req_write_d = 1'b1;
          mem_req_addr_d  = {tag_q[fl_set_q][fl_way_q], fl_set_q, {OFF_W{1'b0}}};
          mem_wdata_d     = data_q[fl_set_q][fl_way_q];
        end else begin
          valid_d[fl_set_q][fl_way_q] = 1'b0;
          dirty_d[fl_set_q][fl_way_q] = 1'b0;
          fl_set_d = fl_set_nxt;
          fl_way_d = fl_way_nxt;
          if (fl_last) begin
            flush_done_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end

      S_FLUSH_WB: begin
        if (bus.mem_ready) begin
          mem_req_valid_d = 1'b0;
          mem_req_write_d = 1'b0;
          valid_d[fl_set_q][fl_way_q] = 1'b0;
          dirty_d[fl_set_q][fl_way_q] = 1'b0;
          fl_set_d = fl_set_nxt;
          fl_way_d = fl_way_nxt;
          if (fl_last) begin
            flush_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_FLUSH_SCAN;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // control state and line metadata; reset drops all lines including dirty ones
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      miss_tag_q      <= '0;
      miss_idx_q      <= '0;
      victim_q        <= '0;
      fl_set_q        <= '0;
      fl_way_q        <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_wdata_q     <= '0;
      flush_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      dirty_q         <= dirty_d;
      rr_q            <= rr_d;
      miss_tag_q      <= miss_tag_d;
      miss_idx_q      <= miss_idx_d;
      victim_q        <= victim_d;
      fl_set_q        <= fl_set_d;
      fl_way_q        <= fl_way_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_write_q <= mem_req_write_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      flush_done_q    <= flush_done_d;
    end
  end

  // tag and data arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_sa.sv
// tb/tb_dcache_sa.sv - scoreboard bench for dcache_sa with a line-memory responder
module tb_dcache_sa;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_sa_if #(.LINE_BITS(128)) bus ();

  dcache_sa #(.LINE_BITS(128), .NUM_SETS(4), .NUM_WAYS(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic         w;
    logic [31:0]  a;
    logic [127:0] d;
  } mem_exp_t;

  mem_exp_t     exp_mem_q[$];
  logic [31:0]  exp_rd_q[$];
  logic [127:0] mem_lines[logic [31:0]];
  int           mem_delay = 3;
  bit           resp_busy = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] a);
    if (mem_lines.exists(a)) return mem_lines[a];
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  task automatic push_mem(input logic w, input logic [31:0] a, input logic [127:0] d);
    mem_exp_t e;
    e.w = w; e.a = a; e.d = d;
    exp_mem_q.push_back(e);
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    bus.req_write  = wr;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_funct3 = f3;
    bus.req_valid  = 1'b1;
  endtask

  // one access: wait for hit, compare data and latency (cycles from request to hit)
  task automatic access(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [31:0] exp_rd, input int exp_cyc);
    int cyc;
    logic [31:0] e;
    exp_rd_q.push_back(exp_rd);
    drive_req(wr, a, wd, f3);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (bus.hit || cyc > 200) break;
      cyc++;
      @(posedge clk); #1;
    end
    e = exp_rd_q.pop_front();
    check({tag, "_hit"}, bus.hit, 1'b1);
    if (!wr) check({tag, "_rdata"}, bus.rdata, e);
    check({tag, "_lat"}, cyc, exp_cyc);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic mis_access(input string tag, input logic wr, input logic [31:0] a, input logic [2:0] f3);
    drive_req(wr, a, 32'hFFFF_FFFF, f3);
    @(negedge clk);
    check({tag, "_mis"}, bus.misaligned, 1'b1);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_hit"}, bus.hit, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_memvalid"}, bus.mem_req_valid, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_flush(input string tag, input int exp_cyc);
    int cyc;
    bus.flush_req = 1'b1;
    @(posedge clk); #1;
    bus.flush_req = 1'b0;
    cyc = 1;
    while (1) begin
      @(negedge clk);
      if (bus.flush_done || cyc > 300) break;
      cyc++;
      @(posedge clk); #1;
    end
    check({tag, "_done"}, bus.flush_done, 1'b1);
    check({tag, "_len"}, cyc, exp_cyc);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_pulse"}, bus.flush_done, 1'b0);
    @(posedge clk); #1;
  endtask

  // line memory: compares each request against the scoreboard, answers after mem_delay cycles
  initial begin : responder
    logic         t_w;
    logic [31:0]  t_a;
    logic [127:0] t_d;
    mem_exp_t     e;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_valid === 1'b1) begin
        resp_busy = 1;
        t_w = bus.mem_req_write;
        t_a = bus.mem_req_addr;
        t_d = bus.mem_wdata;
        if (exp_mem_q.size() == 0) begin
          check("mem_unexpected", {t_w, t_a}, 33'd0);
        end else begin
          e = exp_mem_q.pop_front();
          check("mem_write", t_w, e.w);
          check("mem_addr", t_a, e.a);
          if (e.w) check("mem_wdata", t_d, e.d);
        end
        repeat (mem_delay) @(negedge clk);
        if (bus.mem_req_valid) check("mem_addr_stable", bus.mem_req_addr, t_a);
        bus.mem_rdata = t_w ? 128'd0 : line_of(t_a);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check("mem_deassert", bus.mem_req_valid, 1'b0);
        if (t_w) mem_lines[t_a] = t_d;
        resp_busy = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int n;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = F_W;
    bus.flush_req  = 1'b0;
    mem_lines[32'h100] = 128'h44444444_33333333_22222222_11111111;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_hit", bus.hit, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_mis", bus.misaligned, 1'b0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_memvalid", bus.mem_req_valid, 1'b0);
    check("rst_memwrite", bus.mem_req_write, 1'b0);
    check("rst_memaddr", bus.mem_req_addr, 32'd0);
    check("rst_flushdone", bus.flush_done, 1'b0);
    @(posedge clk); #1;

    // cold miss and hit-side loads/stores
    push_mem(1'b0, 32'h100, '0);
    access("cold_lw", 1'b0, 32'h104, 0, F_W, 32'h22222222, 5);
    access("sb_hit", 1'b1, 32'h105, 32'hAB, F_B, 0, 0);
    access("lw_merged", 1'b0, 32'h104, 0, F_W, 32'h2222AB22, 0);
    access("lb", 1'b0, 32'h105, 0, F_B, 32'hFFFFFFAB, 0);
    access("lbu", 1'b0, 32'h105, 0, F_BU, 32'h000000AB, 0);
    access("lh", 1'b0, 32'h104, 0, F_H, 32'hFFFFAB22, 0);
    access("lhu", 1'b0, 32'h104, 0, F_HU, 32'h0000AB22, 0);

    // misaligned accesses leave contents alone
    mis_access("mis_lw", 1'b0, 32'h102, F_W);
    mis_access("mis_sh", 1'b1, 32'h101, F_H);
    access("post_mis_w0", 1'b0, 32'h100, 0, F_W, 32'h11111111, 0);
    access("post_mis_w1", 1'b0, 32'h104, 0, F_W, 32'h2222AB22, 0);

    // eviction: way1 fill, then dirty victim way0 written back before 0x300 fill
    push_mem(1'b0, 32'h200, '0);
    access("fill_200", 1'b0, 32'h200, 0, F_W, 32'h200, 5);
    push_mem(1'b1, 32'h100, 128'h44444444_33333333_2222AB22_11111111);
    push_mem(1'b0, 32'h300, '0);
    access("evict_300", 1'b0, 32'h300, 0, F_W, 32'h300, 10);
    // round robin now points at way1 (0x200), so 0x400 must replace it, keeping 0x300
    push_mem(1'b0, 32'h400, '0);
    access("fill_400", 1'b0, 32'h408, 0, F_W, 32'h408, 5);
    access("keep_300", 1'b0, 32'h30C, 0, F_W, 32'h30C, 0);

    // store miss allocates, then flush writes back exactly the dirty line
    push_mem(1'b0, 32'h200, '0);
    access("sw_200", 1'b1, 32'h200, 32'hDEADBEEF, F_W, 0, 5);
    push_mem(1'b1, 32'h200, {32'h20C, 32'h208, 32'h204, 32'hDEADBEEF});
    do_flush("flush_dirty", 13);
    do_flush("flush_clean", 9);
    check("flush_no_extra_mem", exp_mem_q.size(), 0);
    push_mem(1'b0, 32'h200, '0);
    access("refetch_200", 1'b0, 32'h200, 0, F_W, 32'hDEADBEEF, 5);

    // reset in the middle of a fill
    mem_delay = 20;
    push_mem(1'b0, 32'h100, '0);
    drive_req(1'b0, 32'h100, 0, F_W);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("fill_active", bus.mem_req_valid, 1'b1);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_fill_memvalid", bus.mem_req_valid, 1'b0);
    check("rst_fill_busy", bus.busy, 1'b0);
    n = 0;
    while (resp_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resp_drained", resp_busy, 1'b0);
    mem_delay = 3;
    @(posedge clk); #1;
    push_mem(1'b0, 32'h100, '0);
    access("post_rst_lw", 1'b0, 32'h104, 0, F_W, 32'h2222AB22, 5);
    check("mem_queue_empty", exp_mem_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
